// File: rtl/seq_101_mealy_fsm.sv
// -----------------------------------------------------------------------------
// seq_101_mealy_fsm
//   Mealy recogniser for the serial pattern 1-0-1 on din (first bit first).
//   detect is combinational: it is high during the cycle in which the final
//   '1' is presented, before the clock edge that consumes it.
//
// Parameters
//   OVERLAP : 1 = overlapping detection (the closing '1' may start a new match)
//             0 = non-overlapping detection (a hit restarts from idle)
//
// Ports
//   clk    : in  1b  single clock, all state updates on its rising edge
//   rst    : in  1b  synchronous active-high reset; also masks detect
//   din    : in  1b  serial data, one bit consumed per rising edge
//   detect : out 1b  high while the current din completes "101"
// -----------------------------------------------------------------------------
module seq_101_mealy_fsm #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic detect
);

  // 2-bit binary encoding; 2'b11 is unused and treated as illegal.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_10   = 2'b10,
    S_BAD  = 2'b11
  } state_e;

  state_e state_q, state_d;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and Mealy output.
  always_comb begin
    state_d = S_IDLE;
    detect  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = din ? S_1 : S_IDLE;
      S_1:    state_d = din ? S_1 : S_10;
      S_10: begin
        if (din) begin
          // rst masks the output so a reset cycle never reports a hit.
          detect  = ~rst;
          // The closing '1' is reused as the first bit of the next match
          // only when overlapping detection is enabled.
          state_d = OVERLAP ? S_1 : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // Illegal encoding: recover to idle, never report a hit.
      S_BAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_101_mealy_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_101_mealy_fsm
//   Directed bench driving one OVERLAP=1 and one OVERLAP=0 instance from the
//   same clk/rst/din. Inputs change on the falling edge; detect is sampled
//   1 time unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_seq_101_mealy_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic det_ov, det_no;

  int checks   = 0;
  int failures = 0;

  seq_101_mealy_fsm #(.OVERLAP(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .din(din), .detect(det_ov)
  );

  seq_101_mealy_fsm #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .din(din), .detect(det_no)
  );

  always #5 clk = ~clk;

  // One cycle: present din/rst, check both detects, then let the edge consume.
  task automatic step(input string tag, input logic r, input logic d,
                      input logic exp_ov, input logic exp_no);
    @(negedge clk);
    rst = r;
    din = d;
    #1;
    checks++;
    assert (det_ov === exp_ov) else begin
      failures++;
      $error("FAIL %s overlap detect got=%b want=%b", tag, det_ov, exp_ov);
    end
    checks++;
    assert (det_no === exp_no) else begin
      failures++;
      $error("FAIL %s nonoverlap detect got=%b want=%b", tag, det_no, exp_no);
    end
  endtask

  initial begin
    // Reset with din=1: state unknown beforehand, detect must still be 0.
    step("rst_a",   1, 1, 0, 0);
    step("rst_b",   1, 1, 0, 0);

    // Basic 1,0,1
    step("basic1",  0, 1, 0, 0);
    step("basic2",  0, 0, 0, 0);
    step("basic3",  0, 1, 1, 1);
    step("rst_c",   1, 0, 0, 0);

    // 1,0,1,0,1: two hits with overlap, one without
    step("ovl1",    0, 1, 0, 0);
    step("ovl2",    0, 0, 0, 0);
    step("ovl3",    0, 1, 1, 1);
    step("ovl4",    0, 0, 0, 0);
    step("ovl5",    0, 1, 1, 0);
    step("rst_d",   1, 0, 0, 0);

    // 1,0,1,1,0,1: hits on bits 3 and 6 for both modes
    step("rep1",    0, 1, 0, 0);
    step("rep2",    0, 0, 0, 0);
    step("rep3",    0, 1, 1, 1);
    step("rep4",    0, 1, 0, 0);
    step("rep5",    0, 0, 0, 0);
    step("rep6",    0, 1, 1, 1);
    step("rst_e",   1, 0, 0, 0);

    // Runs of ones never detect
    step("ones1",   0, 1, 0, 0);
    step("ones2",   0, 1, 0, 0);
    step("ones3",   0, 1, 0, 0);
    step("ones4",   0, 1, 0, 0);
    step("rst_f",   1, 0, 0, 0);

    // 1,0,0,1: the second 0 breaks the match
    step("brk1",    0, 1, 0, 0);
    step("brk2",    0, 0, 0, 0);
    step("brk3",    0, 0, 0, 0);
    step("brk4",    0, 1, 0, 0);
    step("rst_g",   1, 0, 0, 0);

    // Mid-pattern reset: reach S_10, then rst with din=1 (would be a hit)
    step("mid1",    0, 1, 0, 0);
    step("mid2",    0, 0, 0, 0);
    step("mid_rst", 1, 1, 0, 0);
    step("mid3",    0, 0, 0, 0);
    step("mid4",    0, 1, 0, 0);
    step("mid5",    0, 1, 0, 0);
    step("mid6",    0, 0, 0, 0);
    step("mid7",    0, 1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
